// File: rtl/l1_strm_sched_if.sv
`default_nettype none
// ============================================================================
// l1_strm_sched_if : read/fill/init handshakes and state taps of l1_strm_sched
// Revision: 1.0
// ============================================================================
interface l1_strm_sched_if #(
  parameter int NSTRMS    = 64,
  parameter int SID_WIDTH = $clog2(NSTRMS),
  parameter int NPORTS    = 8,
  parameter int PTR_WIDTH = 4,
  parameter int CNT_WIDTH = PTR_WIDTH + 1
);
  logic [NPORTS-1:0]           i_rd_v;
  logic [NPORTS-1:0]           i_rd_r;
  logic [NPORTS*SID_WIDTH-1:0] i_rd_sid;
  logic [NPORTS-1:0]           o_cmp_sid_v;
  logic [NPORTS*SID_WIDTH-1:0] o_cmp_sid_d;
  logic [NSTRMS*PTR_WIDTH-1:0] o_ptrs;
  logic                        i_wr_v;
  logic                        i_wr_r;
  logic [SID_WIDTH-1:0]        i_wr_sid;
  logic                        i_srst_v;
  logic [SID_WIDTH-1:0]        i_srst_sid;
  logic                        i_srst_r;
  logic                        o_err_v;
  logic [NSTRMS*CNT_WIDTH-1:0] o_occ;

  modport master (
    output i_rd_v, i_rd_sid, i_wr_v, i_wr_sid, i_srst_v, i_srst_sid,
    input  i_rd_r, o_cmp_sid_v, o_cmp_sid_d, o_ptrs, i_wr_r, i_srst_r,
           o_err_v, o_occ
  );

  modport slave (
    input  i_rd_v, i_rd_sid, i_wr_v, i_wr_sid, i_srst_v, i_srst_sid,
    output i_rd_r, o_cmp_sid_v, o_cmp_sid_d, o_ptrs, i_wr_r, i_srst_r,
           o_err_v, o_occ
  );
endinterface
`default_nettype wire

// File: rtl/l1_strm_sched.sv
`default_nettype none
// ============================================================================
// l1_strm_sched : fixed-priority multi-port read scheduler with per-stream
//                 read pointers, occupancy counters and stream init/fill.
// Revision: 1.0
// ============================================================================
module l1_strm_sched #(
  parameter int NSTRMS    = 64,
  parameter int SID_WIDTH = $clog2(NSTRMS),
  parameter int NPORTS    = 8,
  parameter int PTR_WIDTH = 4,
  parameter int CNT_WIDTH = PTR_WIDTH + 1
) (
  input  logic           clk,
  input  logic           reset,
  l1_strm_sched_if.slave bus
);
  localparam int c_gw = $clog2(NPORTS + 1);
  localparam int c_cw = (CNT_WIDTH > c_gw) ? CNT_WIDTH : c_gw;
  localparam logic [CNT_WIDTH-1:0] c_depth = CNT_WIDTH'(1 << PTR_WIDTH);

  logic [PTR_WIDTH-1:0] ptr_q [NSTRMS];
  logic [PTR_WIDTH-1:0] ptr_d [NSTRMS];
  logic [CNT_WIDTH-1:0] occ_q [NSTRMS];
  logic [CNT_WIDTH-1:0] occ_d [NSTRMS];
  logic [NSTRMS-1:0]    act_q;
  logic [NSTRMS-1:0]    act_d;
  logic                 err_q;
  logic                 err_d;

  logic [SID_WIDTH-1:0] w_sid [NPORTS];
  logic [NPORTS-1:0]    w_gnt;
  logic [NPORTS-1:0]    w_take;
  logic [c_gw-1:0]      w_n;
  logic                 w_wr_r;
  logic                 w_srst_wr;
  logic                 w_fill_ok;

  for (genvar p = 0; p < NPORTS; p++) begin : g_sid
    assign w_sid[p] = bus.i_rd_sid[p*SID_WIDTH +: SID_WIDTH];
  end

  for (genvar s = 0; s < NSTRMS; s++) begin : g_pack
    assign bus.o_ptrs[s*PTR_WIDTH +: PTR_WIDTH] = ptr_q[s];
    assign bus.o_occ[s*CNT_WIDTH +: CNT_WIDTH]  = occ_q[s];
  end

  // Port p sees occupancy minus grants already taken by lower ports on its sid.
  always_comb begin
    w_gnt = '0;
    w_n   = '0;
    for (int p = 0; p < NPORTS; p++) begin
      w_n = '0;
      for (int q = 0; q < p; q++) begin
        if (bus.i_rd_v[q] && w_gnt[q] && (w_sid[q] == w_sid[p])) begin
          w_n = w_n + 1'b1;
        end
      end
      w_gnt[p] = reset && act_q[w_sid[p]]
                 && (c_cw'(occ_q[w_sid[p]]) > c_cw'(w_n))
                 && !(bus.i_srst_v && (bus.i_srst_sid == w_sid[p]));
    end
  end

  assign w_take    = bus.i_rd_v & w_gnt;
  assign w_wr_r    = !(act_q[bus.i_wr_sid] && (occ_q[bus.i_wr_sid] == c_depth));
  assign w_srst_wr = bus.i_srst_v && (bus.i_srst_sid == bus.i_wr_sid);
  assign w_fill_ok = bus.i_wr_v && w_wr_r && act_q[bus.i_wr_sid] && !w_srst_wr;

  assign bus.i_rd_r      = w_gnt;
  assign bus.o_cmp_sid_v = w_take;
  assign bus.o_cmp_sid_d = bus.i_rd_sid;
  assign bus.i_wr_r      = w_wr_r;
  assign bus.i_srst_r    = 1'b1;
  assign bus.o_err_v     = err_q;

  // Init is applied last so it overrides any fill on the same stream.
  always_comb begin
    ptr_d = ptr_q;
    occ_d = occ_q;
    act_d = act_q;
    for (int p = 0; p < NPORTS; p++) begin
      if (w_take[p]) begin
        ptr_d[w_sid[p]] = ptr_d[w_sid[p]] + 1'b1;
        occ_d[w_sid[p]] = occ_d[w_sid[p]] - 1'b1;
      end
    end
    if (w_fill_ok) begin
      occ_d[bus.i_wr_sid] = occ_d[bus.i_wr_sid] + 1'b1;
    end
    if (bus.i_srst_v) begin
      ptr_d[bus.i_srst_sid] = '0;
      occ_d[bus.i_srst_sid] = '0;
      act_d[bus.i_srst_sid] = 1'b1;
    end
    err_d = bus.i_wr_v && !act_q[bus.i_wr_sid] && !w_srst_wr;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < NSTRMS; s++) begin
        ptr_q[s] <= '0;
        occ_q[s] <= '0;
      end
      act_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      occ_q <= occ_d;
      act_q <= act_d;
      err_q <= err_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_l1_strm_sched.sv
`default_nettype none
// ============================================================================
// tb_l1_strm_sched : directed self-checking bench for l1_strm_sched
// Revision: 1.0
// ============================================================================
module tb_l1_strm_sched;
  localparam int NSTRMS    = 64;
  localparam int SID_WIDTH = 6;
  localparam int NPORTS    = 8;
  localparam int PTR_WIDTH = 4;
  localparam int CNT_WIDTH = 5;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  l1_strm_sched_if #(
    .NSTRMS(NSTRMS), .SID_WIDTH(SID_WIDTH), .NPORTS(NPORTS),
    .PTR_WIDTH(PTR_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) bus ();

  l1_strm_sched #(
    .NSTRMS(NSTRMS), .SID_WIDTH(SID_WIDTH), .NPORTS(NPORTS),
    .PTR_WIDTH(PTR_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PTR_WIDTH-1:0] ptr_of(input int s);
    logic [NSTRMS*PTR_WIDTH-1:0] v;
    v = bus.o_ptrs;
    return v[s*PTR_WIDTH +: PTR_WIDTH];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] occ_of(input int s);
    logic [NSTRMS*CNT_WIDTH-1:0] v;
    v = bus.o_occ;
    return v[s*CNT_WIDTH +: CNT_WIDTH];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_rd_v     = '0;
    bus.i_rd_sid   = '0;
    bus.i_wr_v     = 1'b0;
    bus.i_wr_sid   = '0;
    bus.i_srst_v   = 1'b0;
    bus.i_srst_sid = '0;
  endtask

  task automatic set_rd(input int p, input int s);
    bus.i_rd_sid[p*SID_WIDTH +: SID_WIDTH] = SID_WIDTH'(s);
  endtask

  task automatic do_srst(input int s);
    bus.i_srst_v   = 1'b1;
    bus.i_srst_sid = SID_WIDTH'(s);
    step();
    bus.i_srst_v   = 1'b0;
  endtask

  task automatic do_fill(input int s, input int n);
    bus.i_wr_sid = SID_WIDTH'(s);
    bus.i_wr_v   = 1'b1;
    repeat (n) step();
    bus.i_wr_v   = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    step();
    step();
    n_cmp++; if (bus.i_rd_r !== 8'h00) begin n_bad++; $display("FAIL reset_rd_r got %h want 00", bus.i_rd_r); end
    n_cmp++; if (bus.o_cmp_sid_v !== 8'h00) begin n_bad++; $display("FAIL reset_cmp_v got %h want 00", bus.o_cmp_sid_v); end
    n_cmp++; if (bus.i_wr_r !== 1'b1) begin n_bad++; $display("FAIL reset_wr_r got %b want 1", bus.i_wr_r); end
    n_cmp++; if (bus.o_err_v !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", bus.o_err_v); end
    n_cmp++; if (bus.o_occ !== '0) begin n_bad++; $display("FAIL reset_occ got nonzero want 0"); end
    n_cmp++; if (bus.o_ptrs !== '0) begin n_bad++; $display("FAIL reset_ptrs got nonzero want 0"); end
    n_cmp++; if (bus.i_srst_r !== 1'b1) begin n_bad++; $display("FAIL srst_r got %b want 1", bus.i_srst_r); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_inactive();
    idle();
    bus.i_rd_v = 8'hFF;
    for (int p = 0; p < NPORTS; p++) set_rd(p, 3);
    #1;
    n_cmp++; if (bus.i_rd_r !== 8'h00) begin n_bad++; $display("FAIL inact_rd_r got %h want 00", bus.i_rd_r); end
    bus.i_wr_v   = 1'b1;
    bus.i_wr_sid = 6'd3;
    #1;
    n_cmp++; if (bus.i_wr_r !== 1'b1) begin n_bad++; $display("FAIL inact_wr_r got %b want 1", bus.i_wr_r); end
    step();
    idle();
    n_cmp++; if (bus.o_err_v !== 1'b1) begin n_bad++; $display("FAIL inact_err got %b want 1", bus.o_err_v); end
    n_cmp++; if (occ_of(3) !== 5'd0) begin n_bad++; $display("FAIL inact_occ got %0d want 0", occ_of(3)); end
    step();
    n_cmp++; if (bus.o_err_v !== 1'b0) begin n_bad++; $display("FAIL inact_err_pulse got %b want 0", bus.o_err_v); end
  endtask

  task automatic test_single_stream();
    idle();
    do_srst(3);
    do_fill(3, 4);
    n_cmp++; if (occ_of(3) !== 5'd4) begin n_bad++; $display("FAIL single_occ got %0d want 4", occ_of(3)); end
    bus.i_rd_v = 8'hFF;
    for (int p = 0; p < NPORTS; p++) set_rd(p, 3);
    #1;
    n_cmp++; if (bus.i_rd_r !== 8'h0F) begin n_bad++; $display("FAIL single_rd_r got %h want 0f", bus.i_rd_r); end
    n_cmp++; if (bus.o_cmp_sid_v !== 8'h0F) begin n_bad++; $display("FAIL single_cmp_v got %h want 0f", bus.o_cmp_sid_v); end
    n_cmp++; if (bus.o_cmp_sid_d !== 48'h0C30C30C30C3) begin n_bad++; $display("FAIL single_cmp_d got %h want 0c30c30c30c3", bus.o_cmp_sid_d); end
    step();
    idle();
    n_cmp++; if (ptr_of(3) !== 4'd4) begin n_bad++; $display("FAIL single_ptr got %0d want 4", ptr_of(3)); end
    n_cmp++; if (occ_of(3) !== 5'd0) begin n_bad++; $display("FAIL single_occ_after got %0d want 0", occ_of(3)); end
  endtask

  task automatic test_two_streams();
    idle();
    do_srst(5);
    do_srst(9);
    do_fill(5, 2);
    do_fill(9, 2);
    bus.i_rd_v = 8'h1F;
    set_rd(0, 5); set_rd(1, 9); set_rd(2, 5); set_rd(3, 9); set_rd(4, 5);
    #1;
    n_cmp++; if (bus.i_rd_r !== 8'h0F) begin n_bad++; $display("FAIL two_rd_r got %h want 0f", bus.i_rd_r); end
    n_cmp++; if (bus.o_cmp_sid_v !== 8'h0F) begin n_bad++; $display("FAIL two_cmp_v got %h want 0f", bus.o_cmp_sid_v); end
    step();
    idle();
    n_cmp++; if (ptr_of(5) !== 4'd2) begin n_bad++; $display("FAIL two_ptr5 got %0d want 2", ptr_of(5)); end
    n_cmp++; if (ptr_of(9) !== 4'd2) begin n_bad++; $display("FAIL two_ptr9 got %0d want 2", ptr_of(9)); end
    n_cmp++; if (occ_of(5) !== 5'd0) begin n_bad++; $display("FAIL two_occ5 got %0d want 0", occ_of(5)); end
  endtask

  task automatic test_wrap_full();
    int occ_max;
    occ_max = 0;
    idle();
    do_srst(7);
    bus.i_wr_sid = 6'd7;
    bus.i_wr_v   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (int'(occ_of(7)) > occ_max) occ_max = int'(occ_of(7));
    end
    n_cmp++; if (occ_of(7) !== 5'd16) begin n_bad++; $display("FAIL wrap_full_occ got %0d want 16", occ_of(7)); end
    n_cmp++; if (bus.i_wr_r !== 1'b0) begin n_bad++; $display("FAIL wrap_full_wr_r got %b want 0", bus.i_wr_r); end
    bus.i_rd_v = 8'h01;
    set_rd(0, 7);
    #1;
    n_cmp++; if (bus.i_rd_r[0] !== 1'b1) begin n_bad++; $display("FAIL wrap_full_rd got %b want 1", bus.i_rd_r[0]); end
    n_cmp++; if (bus.i_wr_r !== 1'b0) begin n_bad++; $display("FAIL wrap_stall_wr_r got %b want 0", bus.i_wr_r); end
    step();
    n_cmp++; if (occ_of(7) !== 5'd15) begin n_bad++; $display("FAIL wrap_stall_occ got %0d want 15", occ_of(7)); end
    for (int i = 0; i < 19; i++) begin
      step();
      if (int'(occ_of(7)) > occ_max) occ_max = int'(occ_of(7));
    end
    idle();
    n_cmp++; if (ptr_of(7) !== 4'd4) begin n_bad++; $display("FAIL wrap_ptr got %0d want 4", ptr_of(7)); end
    n_cmp++; if (occ_of(7) !== 5'd15) begin n_bad++; $display("FAIL wrap_occ got %0d want 15", occ_of(7)); end
    n_cmp++; if (occ_max > 16) begin n_bad++; $display("FAIL wrap_occ_max got %0d want <=16", occ_max); end
  endtask

  task automatic test_srst_collision();
    idle();
    do_srst(2);
    do_fill(2, 4);
    bus.i_rd_v = 8'h01;
    set_rd(0, 2);
    step();
    idle();
    n_cmp++; if (occ_of(2) !== 5'd3) begin n_bad++; $display("FAIL coll_pre_occ got %0d want 3", occ_of(2)); end
    n_cmp++; if (ptr_of(2) !== 4'd1) begin n_bad++; $display("FAIL coll_pre_ptr got %0d want 1", ptr_of(2)); end
    bus.i_srst_v   = 1'b1;
    bus.i_srst_sid = 6'd2;
    bus.i_rd_v     = 8'h01;
    set_rd(0, 2);
    bus.i_wr_v     = 1'b1;
    bus.i_wr_sid   = 6'd2;
    #1;
    n_cmp++; if (bus.i_rd_r[0] !== 1'b0) begin n_bad++; $display("FAIL coll_rd_r got %b want 0", bus.i_rd_r[0]); end
    n_cmp++; if (bus.i_wr_r !== 1'b1) begin n_bad++; $display("FAIL coll_wr_r got %b want 1", bus.i_wr_r); end
    step();
    idle();
    n_cmp++; if (bus.o_err_v !== 1'b0) begin n_bad++; $display("FAIL coll_err got %b want 0", bus.o_err_v); end
    n_cmp++; if (ptr_of(2) !== 4'd0) begin n_bad++; $display("FAIL coll_ptr got %0d want 0", ptr_of(2)); end
    n_cmp++; if (occ_of(2) !== 5'd0) begin n_bad++; $display("FAIL coll_occ got %0d want 0", occ_of(2)); end
    do_fill(2, 1);
    n_cmp++; if (occ_of(2) !== 5'd1) begin n_bad++; $display("FAIL coll_refill_occ got %0d want 1", occ_of(2)); end
  endtask

  task automatic test_mid_reset();
    idle();
    do_srst(1);
    do_fill(1, 6);
    n_cmp++; if (occ_of(1) !== 5'd6) begin n_bad++; $display("FAIL mrst_pre_occ got %0d want 6", occ_of(1)); end
    bus.i_rd_v = 8'h03;
    set_rd(0, 1);
    set_rd(1, 1);
    bus.i_wr_v   = 1'b1;
    bus.i_wr_sid = 6'd1;
    #1;
    n_cmp++; if (bus.i_rd_r[1:0] !== 2'b11) begin n_bad++; $display("FAIL mrst_burst_rd got %b want 11", bus.i_rd_r[1:0]); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.i_rd_r !== 8'h00) begin n_bad++; $display("FAIL mrst_rd_in_reset got %h want 00", bus.i_rd_r); end
    step();
    reset = 1'b1;
    bus.i_wr_v = 1'b0;
    #1;
    n_cmp++; if (bus.o_occ !== '0) begin n_bad++; $display("FAIL mrst_occ got nonzero want 0"); end
    n_cmp++; if (bus.o_ptrs !== '0) begin n_bad++; $display("FAIL mrst_ptrs got nonzero want 0"); end
    n_cmp++; if (bus.i_rd_r !== 8'h00) begin n_bad++; $display("FAIL mrst_rd_r got %h want 00", bus.i_rd_r); end
    idle();
    do_fill(1, 1);
    n_cmp++; if (bus.o_err_v !== 1'b1) begin n_bad++; $display("FAIL mrst_inactive_err got %b want 1", bus.o_err_v); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    idle();
    test_reset();
    test_inactive();
    test_single_stream();
    test_two_streams();
    test_wrap_full();
    test_srst_collision();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/l1_strm_sched.md
Name: l1_strm_sched

Overview:
- Per-stream read scheduler and pointer/occupancy controller for the L1 multi-stream buffer.
- Each cycle it arbitrates up to nports read requests across nstrms streams, with fixed priority (port 0 highest).
- A read is granted only while the requested stream is active and holds enough valid entries.
- It owns the per-stream read pointers and occupancy counters, accepts fill (write) notifications, and supplies the per-port grant vectors consumed by the read-port address logic.

Parameters:
- nstrms, 64, number of streams.
- sid_width, $clog2(nstrms), stream id width.
- nports, 8, number of read ports.
- ptr_width, 4, per-stream pointer width; stream depth D = 2^ptr_width entries.
- cnt_width, ptr_width+1, occupancy counter width (0..D).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- i_rd_v  in  nports  read request valid, one per port.
- i_rd_r  out  nports  read grant (ready), one per port.
- i_rd_sid  in  nports*sid_width  requested stream id per port; port p at bits [(p+1)*sid_width-1 : p*sid_width].
- o_cmp_sid_v  out  nports  granted-this-cycle flag per port (equals i_rd_v & i_rd_r).
- o_cmp_sid_d  out  nports*sid_width  stream id per port (pass-through of i_rd_sid).
- o_ptrs  out  nstrms*ptr_width  registered current read pointer of every stream.
- i_wr_v  in  1  fill notification: one entry written to stream i_wr_sid.
- i_wr_r  out  1  fill accepted.
- i_wr_sid  in  sid_width  stream being filled.
- i_srst_v  in  1  stream (re)initialise request.
- i_srst_sid  in  sid_width  stream to initialise.
- i_srst_r  out  1  always 1 (srst accepted every cycle).
- o_err_v  out  1  one-cycle pulse: fill to an inactive stream.
- o_occ  out  nstrms*cnt_width  registered occupancy of every stream.

Behaviour:
- Reset (reset==0 at a clk edge): every ptr=0, occ=0, active=0, o_err_v=0. Combinational outputs then follow the reset state: i_rd_r=0, o_cmp_sid_v=0, i_wr_r=1.
- State per stream s: ptr[s] (ptr_width), occ[s] (cnt_width), active[s] (1 bit).
- Grant rule (combinational from registered state; same-cycle grant, zero latency):
  - n_p = number of ports q<p with i_rd_v[q] & i_rd_r[q] & sid_q==sid_p.
  - i_rd_r[p] = active[sid_p] & (occ[sid_p] > n_p) & ~(i_srst_v & i_srst_sid==sid_p).
  - i_rd_r[p] does not depend on i_rd_v[p], except through lower-numbered ports.
  - A denied port does not block higher-numbered ports.
  - Fills in the same cycle do not bypass into grants; they are visible the next cycle.
- Read-side state update (next edge), per stream s:
  - g_s = number of granted ports on s this cycle.
  - ptr[s] <= (ptr[s] + g_s) mod D; wrap-around is natural overflow.
- Fill:
  - i_wr_r = ~(active[i_wr_sid] & occ[i_wr_sid]==D).
  - Accepted fill (i_wr_v & i_wr_r) to an active stream, without srst on the same sid: w_s = 1.
  - Fill to an inactive stream: accepted (i_wr_r=1), dropped, o_err_v=1 next cycle.
- Occupancy: occ[s] <= occ[s] + w_s - g_s. Invariant 0 <= occ <= D. Simultaneous fill and grant on a full stream is impossible because i_wr_r=0 when full.
- Stream init (i_srst_v): next edge sets ptr[sid]=0, occ[sid]=0, active[sid]=1.
  - srst wins over reads and fills to the same sid in that cycle: reads are not granted; the fill is accepted and dropped, with no o_err_v.
  - srst on an already-active stream re-initialises it.
- Streams with different sids update independently in the same cycle.
- o_err_v is registered, one cycle.
- Reset asserted mid-operation clears all state at that edge regardless of pending handshakes; no grants while reset==0.

Test Plan:
- Reset, then i_rd_v=8'hFF all sid 3 -> i_rd_r=0, o_err_v=0. Then fill sid 3 while inactive -> i_wr_r=1, o_err_v pulses; occ[3] stays 0.
- srst sid 3; 4 fills to sid 3 -> occ[3]=4. Ports 0..7 all request sid 3 -> i_rd_r=8'h0F; next cycle ptr[3]=4, occ[3]=0.
- srst sid 5 and sid 9, 2 fills each. Ports 0,2,4 request sid 5 and ports 1,3 request sid 9 -> grants p0,p2,p1,p3; p4 denied; ptr[5]=2, ptr[9]=2.
- ptr_width=4: cycle 20 reads and 20 fills through sid 7 -> ptr[7]=4 (wrap from 15 to 0); occ never exceeds 16. With occ[7]=16: i_wr_r=0; one read plus fill attempt in the same cycle -> fill stalled, occ=15.
- Same cycle: srst sid 2 (occ=3), read sid 2 on p0, fill sid 2 -> i_rd_r[0]=0, fill dropped without error; next cycle ptr[2]=0, occ[2]=0.
- Assert reset mid-burst with occ[1]=6 -> next cycle all occ=0, active=0, i_rd_r=0.
